// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch-side instruction memory and its boot loader.
package cpu_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] INS_FILL = 32'hffffffff;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction memory: one synchronous write port and one asynchronous read port, no reset.
module imem_ram
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Async read sees the pre-edge word during a same-cycle write.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_loader.sv
// Boot loader: decodes a word-count header, writes big-endian words into instruction
// memory and releases the CPU reset once the whole image is in place.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] ins,
    output logic              cpu_rstd,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned WL_W  = ADDR_W + 1;

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       word_q, word_d;
    logic [WL_W-1:0]   wl_q, wl_d;
    logic              rdy_q, rdy_d;
    logic              cpu_rstd_q, cpu_rstd_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [CNT_W-1:0]  hdr_count;
    logic              we;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] ram_rdata;

    assign accept    = rx_valid && rdy_q;
    assign hdr_count = {count_q[15:8], rx_data};
    assign wdata     = {word_q, rx_data};

    // Next-state, byte assembly and registered-output decode.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        word_d  = word_q;
        wl_d    = wl_q;
        we      = 1'b0;
        if (accept) begin
            case (state_q)
                HDR_HI: begin
                    count_d[15:8] = rx_data;
                    state_d       = HDR_LO;
                end
                HDR_LO: begin
                    count_d = hdr_count;
                    if (hdr_count == '0) begin
                        state_d = DONE;
                    end else if (32'(hdr_count) > DEPTH) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    word_d = {word_q[15:0], rx_data};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        we   = 1'b1;
                        wl_d = wl_q + WL_W'(1);
                        if (CNT_W'(wl_q) + CNT_W'(1) == count_q) begin
                            state_d = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
        rdy_d      = (state_d == HDR_HI) || (state_d == HDR_LO) || (state_d == DATA);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
        cpu_rstd_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q    <= HDR_HI;
            count_q    <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            wl_q       <= '0;
            rdy_q      <= 1'b1;
            cpu_rstd_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            wl_q       <= wl_d;
            rdy_q      <= rdy_d;
            cpu_rstd_q <= cpu_rstd_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    imem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wl_q[ADDR_W-1:0]),
        .wdata (wdata),
        .raddr (pc[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    // Out-of-range fetches return an undefined opcode.
    assign ins = (pc[WORD_W-1:ADDR_W] == '0) ? ram_rdata : INS_FILL;

    assign rx_ready     = rdy_q;
    assign cpu_rstd     = cpu_rstd_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expectations, a negedge monitor checks them.
module tb_imem_loader;

    localparam int K_INS  = 0;
    localparam int K_RSTD = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;
    localparam int K_RDY  = 4;
    localparam int K_WL   = 5;
    localparam int K_ACC  = 6;

    localparam int TIMEOUT_CYC = 200000;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        rstd;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        cpu_rstd;
    logic        load_done;
    logic        load_err;
    logic [8:0]  words_loaded;

    exp_t        sb[$];
    logic [7:0]  stream[$];
    int          passed;
    int          total;
    int          acc_cnt;
    int          exp_acc;
    int          cyc;

    imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk          (clk),
        .rstd         (rstd),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .pc           (pc),
        .ins          (ins),
        .cpu_rstd     (cpu_rstd),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid && rx_ready) acc_cnt <= acc_cnt + 1;
    end

    // Watchdog: fail if the run never completes.
    initial cyc = 0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc > TIMEOUT_CYC) begin
            $display("FAIL timeout: simulation exceeded %0d cycles", TIMEOUT_CYC);
            $display("%0d/%0d checks passed", passed, total + 1);
            $finish;
        end
    end

    // Monitor: drain every queued expectation against the settled DUT outputs.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_INS:   act = ins;
                K_RSTD:  act = 32'(cpu_rstd);
                K_DONE:  act = 32'(load_done);
                K_ERR:   act = 32'(load_err);
                K_RDY:   act = 32'(rx_ready);
                K_WL:    act = 32'(words_loaded);
                default: act = 32'(acc_cnt);
            endcase
            total = total + 1;
            if (act !== e.exp) begin
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end else begin
                passed = passed + 1;
            end
        end
    end

    function automatic void expect_v(input string n, input int k, input logic [31:0] e);
        exp_t x;
        x.name = n;
        x.kind = k;
        x.exp  = e;
        sb.push_back(x);
    endfunction

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            rx_data = 8'($urandom);
            sync();
        end
    endtask

    task automatic drive_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic do_reset();
        rstd = 1'b0;
        #3;
        rstd = 1'b1;
        sync();
    endtask

    // Send the bytes in 'stream'; per byte expect cpu_rstd and words_loaded.
    task automatic load(input bit good, input int stall);
        int n;
        n = stream.size();
        for (int k = 0; k < n; k++) begin
            if (stall > 0 && k > 0) idle(stall);
            drive_byte(stream[k]);
            exp_acc = exp_acc + 1;
            expect_v("cpu_rstd_step", K_RSTD, 32'(good && (k == n - 1)));
            expect_v("words_step", K_WL, (k < 2) ? 32'd0 : 32'((k - 1) / 4));
            sync();
        end
        expect_v("accepts", K_ACC, 32'(exp_acc));
        sync();
    endtask

    task automatic push_word(input logic [31:0] w);
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
    endtask

    task automatic check_ins(input logic [31:0] a, input logic [31:0] e, input string n);
        pc = a;
        expect_v(n, K_INS, e);
        sync();
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        acc_cnt  = 0;
        exp_acc  = 0;
        rstd     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pc       = 32'd0;
        #12;
        rstd = 1'b1;
        sync();

        total = total + 1;
        if (rx_ready !== 1'b1 || cpu_rstd !== 1'b0 || load_done !== 1'b0 ||
            load_err !== 1'b0 || words_loaded !== 9'd0) begin
            $display("FAIL reset state: rdy=%b cpu_rstd=%b done=%b err=%b words=%0d",
                     rx_ready, cpu_rstd, load_done, load_err, words_loaded);
        end else begin
            passed = passed + 1;
        end

        expect_v("rst_rdy", K_RDY, 32'd1);
        expect_v("rst_cpu_rstd", K_RSTD, 32'd0);
        expect_v("rst_done", K_DONE, 32'd0);
        expect_v("rst_err", K_ERR, 32'd0);
        expect_v("rst_words", K_WL, 32'd0);
        sync();

        // Single word.
        stream = {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        load(1'b1, 0);
        expect_v("w1_done", K_DONE, 32'd1);
        expect_v("w1_rdy", K_RDY, 32'd0);
        expect_v("w1_words", K_WL, 32'd1);
        check_ins(32'd0, 32'h12345678, "w1_ins0");

        // Three words with 1-0-1 valid pattern.
        do_reset();
        stream = {8'h00, 8'h03};
        push_word(32'hDEADBEEF);
        push_word(32'h01020304);
        push_word(32'hCAFEF00D);
        load(1'b1, 1);
        expect_v("w3_words", K_WL, 32'd3);
        expect_v("w3_done", K_DONE, 32'd1);
        check_ins(32'd0, 32'hDEADBEEF, "w3_ins0");
        check_ins(32'd1, 32'h01020304, "w3_ins1");
        check_ins(32'd2, 32'hCAFEF00D, "w3_ins2");

        // Zero count: done after the header, further bytes refused.
        do_reset();
        stream = {8'h00, 8'h00};
        load(1'b1, 0);
        expect_v("z_rdy", K_RDY, 32'd0);
        expect_v("z_done", K_DONE, 32'd1);
        expect_v("z_err", K_ERR, 32'd0);
        sync();
        drive_byte(8'h55);
        sync();
        expect_v("z_no_accept", K_ACC, 32'(exp_acc));
        expect_v("z_words", K_WL, 32'd0);
        expect_v("z_cpu_rstd", K_RSTD, 32'd1);
        sync();

        // Overflow: count 257.
        do_reset();
        stream = {8'h01, 8'h01};
        load(1'b0, 0);
        expect_v("ovf_err", K_ERR, 32'd1);
        expect_v("ovf_rdy", K_RDY, 32'd0);
        expect_v("ovf_done", K_DONE, 32'd0);
        sync();
        drive_byte(8'h00);
        idle(4);
        expect_v("ovf_no_accept", K_ACC, 32'(exp_acc));
        expect_v("ovf_cpu_rstd", K_RSTD, 32'd0);
        expect_v("ovf_err_hold", K_ERR, 32'd1);
        expect_v("ovf_words", K_WL, 32'd0);
        sync();

        // Reset mid-load, then a fresh one-word image.
        do_reset();
        stream = {8'h00, 8'h02, 8'h11, 8'h22};
        load(1'b0, 0);
        do_reset();
        expect_v("mid_words", K_WL, 32'd0);
        expect_v("mid_rdy", K_RDY, 32'd1);
        expect_v("mid_done", K_DONE, 32'd0);
        sync();
        stream = {8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        load(1'b1, 0);
        expect_v("mid_done2", K_DONE, 32'd1);
        expect_v("mid_words2", K_WL, 32'd1);
        check_ins(32'd0, 32'hAABBCCDD, "mid_ins0");

        // Full depth, mem[i] = i.
        do_reset();
        stream = {8'h01, 8'h00};
        for (int i = 0; i < 256; i++) push_word(32'(i));
        load(1'b1, 0);
        expect_v("full_words", K_WL, 32'd256);
        expect_v("full_done", K_DONE, 32'd1);
        check_ins(32'd0, 32'd0, "full_ins0");
        check_ins(32'd128, 32'd128, "full_ins128");
        check_ins(32'd255, 32'd255, "full_ins255");
        check_ins(32'd256, 32'hffffffff, "full_ins256");
        check_ins(32'h80000000, 32'hffffffff, "full_ins_hi");

        sync();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
